// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the seven-segment display controller.
package hex_display_pkg;

    typedef enum logic [1:0] {
        MODE_HEX  = 2'd0,
        MODE_UDEC = 2'd1,
        MODE_SDEC = 2'd2
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Active-low gfedcba patterns for 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int unsigned BCD_DIGITS(int unsigned data_w);
        return (data_w * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Request channel of the display controller: value, format and blink mask via valid/ready.
interface hex_display_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DATA_W     = 24
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [1:0]            in_mode;
    logic                  in_lzb;
    logic [NUM_DIGITS-1:0] in_blink;

    modport master (output in_valid, in_data, in_mode, in_lzb, in_blink, input in_ready);
    modport slave  (input in_valid, in_data, in_mode, in_lzb, in_blink, output in_ready);
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: loads on i_start, then one shift-add-3 step per cycle.
module bin2bcd_serial
    import hex_display_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    localparam int unsigned BCD_W = 4 * BCD_DIGITS(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_bin,
    output logic              o_done,
    output logic [BCD_W-1:0]  o_bcd
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [BCD_W-1:0]  w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= CNT_W'(DATA_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Flags the cycle of the final step; o_bcd holds the result from the next cycle on.
    assign o_done = r_busy && (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit seven-segment driver: hex / unsigned / signed decimal rendering with
// leading-zero blanking, per-digit blink and overflow dashes.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_display_ctrl_if.slave       in_bus,
    output logic [7*NUM_DIGITS-1:0] hex_n,
    output logic                    overflow
);
    localparam int unsigned BCD_N = BCD_DIGITS(DATA_W);
    localparam int unsigned BCD_W = 4 * BCD_N;
    localparam int unsigned EXT_N = (BCD_N > NUM_DIGITS) ? BCD_N : NUM_DIGITS;
    localparam int unsigned HEX_W = 4 * NUM_DIGITS;
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {StIdle, StConv, StRender} state_e;

    state_e                  r_state, w_state_next;
    logic                    r_ready, r_dec, r_neg, r_lzb, r_phase;
    logic [DATA_W-1:0]       r_data;
    logic [NUM_DIGITS-1:0]   r_blink, r_bmask;
    logic [7*NUM_DIGITS-1:0] r_seg, r_hex, w_seg, w_hex_next;
    logic                    r_ovf_seg, r_ovf, w_ovf;
    logic [BLK_W-1:0]        r_bcnt;

    logic                    w_accept, w_dec_in, w_neg_in, w_bcd_done;
    logic [DATA_W-1:0]       w_mag;
    logic [BCD_W-1:0]        w_bcd;
    logic [4*EXT_N-1:0]      w_bcd_ext;
    logic [HEX_W+DATA_W-1:0] w_hex_ext;
    logic [3:0]              w_dig [NUM_DIGITS];

    assign w_accept = in_bus.in_valid && r_ready;
    assign w_dec_in = (in_bus.in_mode == MODE_UDEC) || (in_bus.in_mode == MODE_SDEC);
    assign w_neg_in = (in_bus.in_mode == MODE_SDEC) && in_bus.in_data[DATA_W-1];
    assign w_mag    = w_neg_in ? -in_bus.in_data : in_bus.in_data;

    bin2bcd_serial #(.DATA_W(DATA_W)) u_bcd (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_accept && w_dec_in),
        .i_bin  (w_mag),
        .o_done (w_bcd_done),
        .o_bcd  (w_bcd)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_accept) w_state_next = w_dec_in ? StConv : StRender;
            StConv:   if (w_bcd_done) w_state_next = StRender;
            StRender: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        int unsigned msd;
        w_hex_ext = (HEX_W + DATA_W)'(r_data);
        w_bcd_ext = (4 * EXT_N)'(w_bcd);
        w_ovf     = 1'b0;
        msd       = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_dig[k] = r_dec ? w_bcd_ext[4*k +: 4] : w_hex_ext[4*k +: 4];
        end
        if (r_dec) begin
            // A negative value gives up its top digit to the minus sign.
            for (int k = 0; k < EXT_N; k++) begin
                if ((k + int'(r_neg) >= NUM_DIGITS) && (w_bcd_ext[4*k +: 4] != 4'd0)) begin
                    w_ovf = 1'b1;
                end
            end
        end else begin
            w_ovf = |(w_hex_ext >> HEX_W);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_dig[k] != 4'd0) msd = k;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_seg[7*k +: 7] = (r_lzb && (k > msd)) ? SEG_BLANK : SEG_LUT[w_dig[k]];
        end
        if (r_neg) begin
            w_seg[7*(r_lzb ? msd + 1 : NUM_DIGITS - 1) +: 7] = SEG_MINUS;
        end
        if (w_ovf) begin
            w_seg = {NUM_DIGITS{SEG_MINUS}};
        end
    end

    always_comb begin
        w_hex_next = r_seg;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_phase && r_bmask[k]) w_hex_next[7*k +: 7] = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_ready   <= 1'b1;
            r_data    <= '0;
            r_dec     <= 1'b0;
            r_neg     <= 1'b0;
            r_lzb     <= 1'b0;
            r_blink   <= '0;
            r_seg     <= {NUM_DIGITS{SEG_BLANK}};
            r_bmask   <= '0;
            r_ovf_seg <= 1'b0;
            r_hex     <= {NUM_DIGITS{SEG_BLANK}};
            r_ovf     <= 1'b0;
            r_bcnt    <= '0;
            r_phase   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_ready <= 1'b0;
                r_data  <= in_bus.in_data;
                r_dec   <= w_dec_in;
                r_neg   <= w_neg_in;
                r_lzb   <= in_bus.in_lzb;
                r_blink <= in_bus.in_blink;
            end else if (r_state == StIdle) begin
                r_ready <= 1'b1;
            end
            // Content and its blink mask change together, one cycle ahead of the pins.
            if (r_state == StRender) begin
                r_seg     <= w_seg;
                r_bmask   <= r_blink;
                r_ovf_seg <= w_ovf;
            end
            r_hex <= w_hex_next;
            r_ovf <= r_ovf_seg;
            if (r_bcnt == BLK_W'(BLINK_DIV - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + BLK_W'(1);
            end
        end
    end

    assign in_bus.in_ready = r_ready;
    assign hex_n           = r_hex;
    assign overflow        = r_ovf;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised and directed bench for hex_display_ctrl against a behavioural display model.
module tb_hex_display_ctrl;
    localparam int unsigned ND = 6;
    localparam int unsigned DW = 24;
    localparam int unsigned BD = 4;

    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7*ND-1:0] hex_n;
    logic            overflow;
    int              n_checks = 0;
    int              n_fail = 0;

    hex_display_ctrl_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

    hex_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(BD)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_bus  (bus),
        .hex_n   (hex_n),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Display contents for one request, straight from the formatting rules.
    function automatic logic [7*ND-1:0] render(input logic [DW-1:0] data, input logic [1:0] mode,
                                               input logic lzb, output logic ovf);
        longint unsigned mag, p;
        int              dig [ND];
        int              msd;
        logic            neg;
        logic [7*ND-1:0] seg;
        neg = (mode == 2'd2) && data[DW-1];
        mag = neg ? ((64'd1 << DW) - longint'(data)) : longint'(data);
        if (mode == 2'd1 || mode == 2'd2) begin
            p = 1;
            for (int k = 0; k < ND - int'(neg); k++) p = p * 10;
            ovf = (mag >= p);
            p = 1;
            for (int k = 0; k < ND; k++) begin
                dig[k] = int'((mag / p) % 10);
                p = p * 10;
            end
        end else begin
            ovf = (mag >> (4 * ND)) != 0;
            for (int k = 0; k < ND; k++) dig[k] = int'((mag >> (4 * k)) & 15);
        end
        msd = 0;
        for (int k = 0; k < ND; k++) if (dig[k] != 0) msd = k;
        for (int k = 0; k < ND; k++) seg[7*k +: 7] = (lzb && k > msd) ? 7'h7F : LUT[dig[k]];
        if (neg) seg[7*(lzb ? msd + 1 : ND - 1) +: 7] = 7'h3F;
        if (ovf) seg = {ND{7'h3F}};
        return seg;
    endfunction

    // Cycle model: what the pins must show after each rising edge.
    logic [7*ND-1:0] m_content, m_hex, m_pend_seg;
    logic [ND-1:0]   m_mask, m_pend_mask;
    logic            m_ovf_c, m_ovf, m_pend_ovf, m_ready, m_pend, m_phase;
    int              m_cnt, m_wait;
    bit              m_on = 0;

    always begin
        @(posedge clk);
        if (reset) begin
            m_content = {ND{7'h7F}};
            m_hex     = {ND{7'h7F}};
            m_mask    = '0;
            m_ovf_c   = 1'b0;
            m_ovf     = 1'b0;
            m_ready   = 1'b1;
            m_pend    = 1'b0;
            m_phase   = 1'b0;
            m_cnt     = 0;
            m_on      = 1;
        end else if (m_on) begin
            logic acc;
            acc = bus.in_valid && m_ready;
            if (m_pend) begin
                if (m_wait == 1) begin
                    m_content = m_pend_seg;
                    m_mask    = m_pend_mask;
                    m_ovf_c   = m_pend_ovf;
                    m_ready   = 1'b1;
                    m_pend    = 1'b0;
                end else begin
                    m_wait--;
                end
            end
            for (int k = 0; k < ND; k++)
                m_hex[7*k +: 7] = (m_phase && m_mask[k]) ? 7'h7F : m_content[7*k +: 7];
            m_ovf = m_ovf_c;
            if (m_cnt == BD - 1) begin
                m_cnt   = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
            if (acc) begin
                m_pend_seg  = render(bus.in_data, bus.in_mode, bus.in_lzb, m_pend_ovf);
                m_pend_mask = bus.in_blink;
                m_pend      = 1'b1;
                m_wait      = (bus.in_mode == 2'd1 || bus.in_mode == 2'd2) ? DW + 2 : 2;
                m_ready     = 1'b0;
            end
        end
    end

    always begin
        @(negedge clk);
        if (m_on) begin
            check("hex_n", 64'(hex_n), 64'(m_hex));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("in_ready", 64'(bus.in_ready), 64'(m_ready));
        end
    end

    // Issue one request from idle and measure edges until in_ready returns.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic lzb,
                        input logic [ND-1:0] mask, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("idle_before_send", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_lzb   = lzb;
        bus.in_blink = mask;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.in_ready) break;
        end
    endtask

    function automatic logic [DW-1:0] pick_data();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return DW'(999999);
            3:       return DW'(1000000);
            4:       return DW'(24'h800000);
            5:       return DW'(-99999);
            6:       return DW'(-100000);
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int n_blank;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_mode  = 2'd0;
        bus.in_lzb   = 1'b0;
        bus.in_blink = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_hex", 64'(hex_n), 64'(42'h3FF_FFFF_FFFF));
        check("reset_ready", 64'(bus.in_ready), 64'd1);
        check("reset_ovf", 64'(overflow), 64'd0);

        send(24'h00BEEF, 2'd0, 1'b1, '0, lat);
        check("hex_latency", 64'(lat), 64'd2);
        check("hex_beef", 64'(hex_n), 64'({7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}));
        check("hex_beef_ovf", 64'(overflow), 64'd0);

        send(DW'(999999), 2'd1, 1'b0, '0, lat);
        check("dec_latency", 64'(lat), 64'(DW + 2));
        check("udec_999999", 64'(hex_n), 64'({ND{7'h10}}));
        send(DW'(1000000), 2'd1, 1'b1, '0, lat);
        check("udec_ovf_hex", 64'(hex_n), 64'({ND{7'h3F}}));
        check("udec_ovf_flag", 64'(overflow), 64'd1);

        send(24'hFFFF85, 2'd2, 1'b1, '0, lat);
        check("sdec_lzb", 64'(hex_n), 64'({7'h7F, 7'h7F, 7'h3F, 7'h79, 7'h24, 7'h30}));
        check("sdec_lzb_ovf", 64'(overflow), 64'd0);
        send(24'hFFFF85, 2'd2, 1'b0, '0, lat);
        check("sdec_nolzb", 64'(hex_n), 64'({7'h3F, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}));

        send(24'h123456, 2'd0, 1'b0, 6'b000001, lat);
        n_blank = 0;
        for (int i = 0; i < 2 * BD; i++) begin
            @(negedge clk);
            check("blink_steady", 64'(hex_n[7*ND-1:7]),
                  64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
            if (hex_n[6:0] == 7'h7F) n_blank++;
            else check("blink_digit0", 64'(hex_n[6:0]), 64'h02);
        end
        check("blink_blank_count", 64'(n_blank), 64'(BD));

        // Valid held through conversion, then reset part-way.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(654321);
        bus.in_mode  = 2'd1;
        bus.in_blink = '0;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_hex", 64'(hex_n), 64'(42'h3FF_FFFF_FFFF));
        check("midreset_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("after_release_ready", 64'(bus.in_ready), 64'd1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 3) == 0);
            bus.in_data  = pick_data();
            bus.in_mode  = 2'($urandom_range(0, 3));
            bus.in_lzb   = 1'($urandom_range(0, 1));
            bus.in_blink = ($urandom_range(0, 1) == 0) ? '0 : ND'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
